// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one result bit per cycle.
// Multiply is shift-add and divide is restoring, both on operand magnitudes.
// Signs are fixed up when the result is written into the output registers.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [1:0]       op_code,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             cancel,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             neg_a;      // operand 1 negative (signed ops only)
   logic             neg_b;      // operand 2 negative (signed ops only)
   logic [WIDTH-1:0] a_raw;      // dividend as given, returned on divide by zero
   logic [WIDTH-1:0] mag_b;      // multiplicand / divisor magnitude
   logic [WIDTH-1:0] work_hi;    // partial product high / partial remainder
   logic [WIDTH-1:0] work_lo;    // multiplier / dividend bits shifting into quotient
   logic [WIDTH-1:0] res_hi_q;
   logic [WIDTH-1:0] res_lo_q;
   logic             div_zero_q;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] nxt_hi;
   logic [WIDTH-1:0] nxt_lo;
   logic [WIDTH-1:0] fin_hi;
   logic [WIDTH-1:0] fin_lo;
   logic [2*WIDTH-1:0] prod_neg;
   logic             b_zero;
   logic             load_sgn;

   assign op_ready  = (state == IDLE);
   assign res_valid = (state == DONE);
   assign res_hi    = res_hi_q;
   assign res_lo    = res_lo_q;
   assign div_zero  = div_zero_q;
   assign b_zero    = (mag_b == '0);
   assign load_sgn  = ~op_code[0];

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? -x : x;
   endfunction

   // One iteration step for both operations, plus sign correction of the final step.
   always_comb begin
      sum      = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_b} : '0);
      shifted  = {work_hi, work_lo[WIDTH-1]};
      fits     = (shifted >= {1'b0, mag_b});
      if (is_div) begin
         nxt_hi = fits ? (shifted[WIDTH-1:0] - mag_b) : shifted[WIDTH-1:0];
         nxt_lo = {work_lo[WIDTH-2:0], fits};
      end else begin
         nxt_hi = sum[WIDTH:1];
         nxt_lo = {sum[0], work_lo[WIDTH-1:1]};
      end
      prod_neg = -{nxt_hi, nxt_lo};
      fin_hi   = nxt_hi;
      fin_lo   = nxt_lo;
      if (!is_div) begin
         if (neg_a ^ neg_b) {fin_hi, fin_lo} = prod_neg;
      end else if (b_zero) begin
         fin_hi = a_raw;
         fin_lo = '1;
      end else begin
         // most-negative / -1 wraps back to most-negative naturally here
         if (neg_a ^ neg_b) fin_lo = -nxt_lo;
         if (neg_a)         fin_hi = -nxt_hi;
      end
   end

   // Control FSM and datapath registers; cancel beats every other request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         is_div     <= 1'b0;
         neg_a      <= 1'b0;
         neg_b      <= 1'b0;
         a_raw      <= '0;
         mag_b      <= '0;
         work_hi    <= '0;
         work_lo    <= '0;
         res_hi_q   <= '0;
         res_lo_q   <= '0;
         div_zero_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (op_valid && !cancel) begin
                  state   <= CALC;
                  cnt     <= '0;
                  is_div  <= op_code[1];
                  neg_a   <= load_sgn & src1[WIDTH-1];
                  neg_b   <= load_sgn & src2[WIDTH-1];
                  a_raw   <= src1;
                  work_hi <= '0;
                  work_lo <= magnitude(src1, load_sgn);
                  mag_b   <= magnitude(src2, load_sgn);
               end
            end
            CALC: begin
               if (cancel) begin
                  state <= IDLE;
               end else begin
                  work_hi <= nxt_hi;
                  work_lo <= nxt_lo;
                  cnt     <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state      <= DONE;
                     res_hi_q   <= fin_hi;
                     res_lo_q   <= fin_lo;
                     div_zero_q <= is_div & b_zero;
                  end
               end
            end
            DONE: begin
               if (cancel || res_ready) begin
                  state      <= IDLE;
                  div_zero_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter at WIDTH=32.
module tb_mdu_iter;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [1:0]  op_code = 2'b00;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        cancel = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        div_zero;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t last;

   mdu_iter #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .src1(src1), .src2(src2), .cancel(cancel),
      .res_valid(res_valid), .res_ready(res_ready), .res_hi(res_hi),
      .res_lo(res_lo), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic signed [63:0] sa, sb64;
      logic [63:0] p;
      int ia, ib;
      sa = $signed(a);
      sb64 = $signed(b);
      ia = a;
      ib = b;
      e.dz = 1'b0;
      case (code)
         2'b00: begin p = sa * sb64; e.hi = p[63:32]; e.lo = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         default: begin
            if (b == 0) begin
               e.hi = a; e.lo = 32'hFFFFFFFF; e.dz = 1'b1;
            end else if (code == 2'b11) begin
               e.lo = a / b; e.hi = a % b;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               e.lo = 32'h80000000; e.hi = 32'h0;
            end else begin
               e.lo = ia / ib; e.hi = ia % ib;
            end
         end
      endcase
      return e;
   endfunction

   // Waits for op_ready, presents the op for one edge, then scrambles the inputs.
   task automatic accept(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
      int k = 0;
      @(posedge clk); #1;
      while (!op_ready && k < 50) begin @(posedge clk); #1; k++; end
      if (!op_ready) chk("ready_wait", 64'd0, 64'd1);
      op_valid = 1'b1; op_code = code; src1 = a; src2 = b;
      @(posedge clk); #1;
      op_valid = 1'b0; op_code = 2'($urandom); src1 = $urandom; src2 = $urandom;
      chk("accepted", {63'd0, op_ready}, 64'd0);
   endtask

   // Counts edges with the accept edge as edge 1.
   task automatic wait_valid(output int n);
      n = 1;
      while (!res_valid && n < 40) begin @(posedge clk); #1; n++; end
   endtask

   task automatic do_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b, input int hold);
      int   n;
      exp_t e;
      res_ready = (hold == 0);
      accept(code, a, b);
      sb.push_back(model(code, a, b));
      wait_valid(n);
      chk("latency", 64'(n), 64'd33);
      if (sb.size() == 0) begin
         chk("sb_empty", 64'd1, 64'd0);
         return;
      end
      e = sb.pop_front();
      if (!res_valid) return;
      chk("res_hi", {32'd0, res_hi}, {32'd0, e.hi});
      chk("res_lo", {32'd0, res_lo}, {32'd0, e.lo});
      chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
      last = e;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", {62'd0, res_valid, op_ready}, 64'd2);
         chk("hold_data", {res_hi, res_lo}, {e.hi, e.lo});
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("post_hs_ctl", {61'd0, res_valid, op_ready, div_zero}, 64'd2);
      chk("post_hs_data", {res_hi, res_lo}, {e.hi, e.lo});
   endtask

   initial begin
      int   n;
      logic seen;
      exp_t e;
      #12;
      chk("reset_ctl", {61'd0, op_ready, res_valid, div_zero}, 64'd4);
      chk("reset_data", {res_hi, res_lo}, 64'd0);
      reset = 1'b0;

      do_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 0);
      do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
      do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 0);
      do_op(2'b11, 32'h00000007, 32'h00000002, 0);
      do_op(2'b11, 32'h00000007, 32'h00000000, 0);
      do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
      do_op(2'b10, 32'hFFFFFFF0, 32'h00000000, 2);
      for (int i = 0; i < 8; i++)
         do_op(2'($urandom_range(0, 3)), $urandom,
               (i % 4 == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom), 0);

      // cancel during the 10th CALC cycle
      res_ready = 1'b1;
      accept(2'b00, 32'h12345678, 32'h9ABCDEF0);
      repeat (9) begin @(posedge clk); #1; end
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      chk("cancel_ctl", {62'd0, op_ready, res_valid}, 64'd2);
      chk("cancel_data", {res_hi, res_lo}, {last.hi, last.lo});
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (res_valid) seen = 1'b1; end
      chk("cancel_no_valid", {63'd0, seen}, 64'd0);

      // op_valid together with cancel in IDLE is not taken
      op_valid = 1'b1; cancel = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0; cancel = 1'b0;
      chk("idle_cancel", {62'd0, op_ready, res_valid}, 64'd2);

      // cancel in DONE drops the result and clears div_zero
      res_ready = 1'b0;
      e = model(2'b11, 32'h00000055, 32'h0);
      accept(2'b11, 32'h00000055, 32'h0);
      wait_valid(n);
      chk("done_cancel_lat", 64'(n), 64'd33);
      chk("done_cancel_res", {31'd0, div_zero, res_lo}, {31'd0, e.dz, e.lo});
      cancel = 1'b1; res_ready = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0; res_ready = 1'b0;
      chk("done_cancel_ctl", {61'd0, op_ready, res_valid, div_zero}, 64'd4);
      chk("done_cancel_data", {res_hi, res_lo}, {e.hi, e.lo});

      // asynchronous reset mid-CALC
      accept(2'b01, 32'hDEADBEEF, 32'h00001234);
      repeat (5) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_ctl", {61'd0, op_ready, res_valid, div_zero}, 64'd4);
      chk("async_rst_data", {res_hi, res_lo}, 64'd0);
      #1 reset = 1'b0;
      do_op(2'b00, 32'd3, 32'd4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
